// File: rtl/fadd_arb_pkg.sv
// Shared types and helpers for the shared floating-point adder arbiter.
// FADD_ARB_STATS_EN (defined by the build) adds the response statistics counter.
package fadd_arb_pkg;

   localparam int FP_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      HOLD = 2'd2
   } state_e;

   // Next round-robin position after ptr, wrapping at n.
   function automatic int rr_next(input int ptr, input int n);
      return (ptr + 1 >= n) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/add_float.sv
// Combinational IEEE-754 single-precision adder, round-to-nearest-even.
// Subnormal inputs are treated as zero-exponent values and tiny results flush to zero.
module add_float
   import fadd_arb_pkg::*;
(
   input  logic [FP_W-1:0] a_i,
   input  logic [FP_W-1:0] b_i,
   output logic [FP_W-1:0] sum_o
);

   logic [31:0]       big_s;
   logic [31:0]       sml_s;
   logic [7:0]        dexp_s;
   logic [26:0]       m_big_s;
   logic [26:0]       m_sml_s;
   logic [26:0]       m_sh_s;
   logic [27:0]       m_sum_s;
   logic [26:0]       m_nrm_s;
   logic [4:0]        lz_s;
   logic              lz_done_s;
   logic              rnd_up_s;
   logic [24:0]       m_rnd_s;
   logic signed [9:0] e_nrm_s;
   logic signed [9:0] e_fin_s;

   // Align, add/subtract magnitudes, normalise, round and pack.
   always_comb begin
      if (b_i[30:0] > a_i[30:0]) begin
         big_s = b_i;
         sml_s = a_i;
      end else begin
         big_s = a_i;
         sml_s = b_i;
      end
      m_big_s = {|big_s[30:23], big_s[22:0], 3'b000};
      m_sml_s = {|sml_s[30:23], sml_s[22:0], 3'b000};
      dexp_s  = big_s[30:23] - sml_s[30:23];
      if (dexp_s >= 8'd27) begin
         m_sh_s = {26'd0, |m_sml_s};
      end else begin
         m_sh_s = (m_sml_s >> dexp_s) | {26'd0, |(m_sml_s & ((27'd1 << dexp_s) - 27'd1))};
      end
      if (big_s[31] == sml_s[31]) begin
         m_sum_s = {1'b0, m_big_s} + {1'b0, m_sh_s};
      end else begin
         m_sum_s = {1'b0, m_big_s} - {1'b0, m_sh_s};
      end
      lz_s      = 5'd0;
      lz_done_s = 1'b0;
      for (int i = 26; i >= 0; i--) begin
         if (lz_done_s || m_sum_s[i]) begin
            lz_done_s = 1'b1;
         end else begin
            lz_s = lz_s + 5'd1;
         end
      end
      if (m_sum_s[27]) begin
         m_nrm_s = m_sum_s[27:1] | {26'd0, m_sum_s[0]};
         e_nrm_s = $signed({2'b00, big_s[30:23]}) + 10'sd1;
      end else begin
         m_nrm_s = m_sum_s[26:0] << lz_s;
         e_nrm_s = $signed({2'b00, big_s[30:23]}) - $signed({5'd0, lz_s});
      end
      // Guard bit decides; ties go to the even mantissa.
      rnd_up_s = m_nrm_s[2] & (m_nrm_s[3] | m_nrm_s[1] | m_nrm_s[0]);
      m_rnd_s  = {1'b0, m_nrm_s[26:3]} + {24'd0, rnd_up_s};
      e_fin_s  = e_nrm_s + $signed({9'd0, m_rnd_s[24]});
      if (m_sum_s == 28'd0) begin
         sum_o = 32'd0;
      end else if (e_fin_s <= 10'sd0) begin
         sum_o = {big_s[31], 31'd0};
      end else if (e_fin_s >= 10'sd255) begin
         sum_o = {big_s[31], 8'hFF, 23'd0};
      end else begin
         sum_o = {big_s[31], e_fin_s[7:0], m_rnd_s[22:0]};
      end
   end

endmodule

// File: rtl/fadd_share_arb_rr_pick.sv
// Combinational round-robin picker: first valid requester after ptr_i, wrapping.
module fadd_rr_pick
   import fadd_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic [N_REQ-1:0] valid_i,
   input  logic [ID_W-1:0]  ptr_i,
   output logic [N_REQ-1:0] grant_o,
   output logic [ID_W-1:0]  idx_o,
   output logic             any_o
);

   int              cand_s;
   logic [ID_W-1:0] cand_idx_s;
   logic            found_s;

   // Walk ptr+1, ptr+2, ... and keep the first requester found.
   always_comb begin
      cand_s     = int'(ptr_i);
      cand_idx_s = ptr_i;
      found_s    = 1'b0;
      idx_o      = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand_s     = rr_next(cand_s, N_REQ);
         cand_idx_s = ID_W'(cand_s);
         if (!found_s && valid_i[cand_idx_s]) begin
            found_s = 1'b1;
            idx_o   = cand_idx_s;
         end else begin
            found_s = found_s;
         end
      end
      any_o   = |valid_i;
      grant_o = found_s ? (N_REQ'(1) << idx_o) : '0;
   end

endmodule

// File: rtl/fadd_share_arb.sv
// Round-robin sharing of one add_float among N_REQ requesters, registered result + owner ID.
// FADD_ARB_STATS_EN adds the saturating op_count port counting delivered responses.
module fadd_share_arb
   import fadd_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
`ifdef FADD_ARB_STATS_EN
   ,
   parameter int CNT_W = 16
`endif
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_REQ-1:0]      req_valid,
   output logic [N_REQ-1:0]      req_ready,
   input  logic [FP_W*N_REQ-1:0] req_a,
   input  logic [FP_W*N_REQ-1:0] req_b,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [FP_W-1:0]       rsp_sum,
   output logic [ID_W-1:0]       rsp_id
`ifdef FADD_ARB_STATS_EN
   ,
   output logic [CNT_W-1:0]      op_count
`endif
);

   state_e          state_q, state_d;
   logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0] id_q, id_d;
   logic [FP_W-1:0] op_a_q, op_a_d;
   logic [FP_W-1:0] op_b_q, op_b_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [FP_W-1:0] rsp_sum_q, rsp_sum_d;
   logic [ID_W-1:0] rsp_id_q, rsp_id_d;

   logic [N_REQ-1:0] pick_grant_s;
   logic [ID_W-1:0]  pick_idx_s;
   logic             pick_any_s;
   logic             grant_en_s;
   logic             grant_s;
   logic [FP_W-1:0]  sum_s;

   fadd_rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
      .valid_i (req_valid),
      .ptr_i   (rr_ptr_q),
      .grant_o (pick_grant_s),
      .idx_o   (pick_idx_s),
      .any_o   (pick_any_s)
   );

   add_float u_add (
      .a_i   (op_a_q),
      .b_i   (op_b_q),
      .sum_o (sum_s)
   );

   // Grant, operand capture and FSM next state.
   always_comb begin
      grant_en_s  = (state_q == IDLE) || ((state_q == HOLD) && rsp_ready);
      grant_s     = grant_en_s && pick_any_s;
      req_ready   = grant_s ? pick_grant_s : '0;
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      id_d        = id_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      rsp_valid_d = rsp_valid_q;
      rsp_sum_d   = rsp_sum_q;
      rsp_id_d    = rsp_id_q;
      case (state_q)
         IDLE: begin
            state_d = grant_s ? CALC : IDLE;
         end
         CALC: begin
            rsp_sum_d   = sum_s;
            rsp_id_d    = id_q;
            rsp_valid_d = 1'b1;
            state_d     = HOLD;
         end
         HOLD: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = grant_s ? CALC : IDLE;
            end else begin
               state_d = HOLD;
            end
         end
         default: begin
            rsp_valid_d = 1'b0;
            state_d     = IDLE;
         end
      endcase
      if (grant_s) begin
         op_a_d   = req_a[FP_W*pick_idx_s +: FP_W];
         op_b_d   = req_b[FP_W*pick_idx_s +: FP_W];
         id_d     = pick_idx_s;
         rr_ptr_d = pick_idx_s;
      end else begin
         rr_ptr_d = rr_ptr_q;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rr_ptr_q    <= ID_W'(N_REQ - 1);
         id_q        <= '0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         rsp_valid_q <= 1'b0;
         rsp_sum_q   <= '0;
         rsp_id_q    <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         id_q        <= id_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_sum_q   <= rsp_sum_d;
         rsp_id_q    <= rsp_id_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_sum   = rsp_sum_q;
   assign rsp_id    = rsp_id_q;

`ifdef FADD_ARB_STATS_EN
   logic [CNT_W-1:0] op_count_q, op_count_d;

   // Saturating count of delivered responses.
   always_comb begin
      if (rsp_valid_q && rsp_ready && (op_count_q != {CNT_W{1'b1}})) begin
         op_count_d = op_count_q + CNT_W'(1);
      end else begin
         op_count_d = op_count_q;
      end
   end

   // Statistics register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_count_q <= '0;
      end else begin
         op_count_q <= op_count_d;
      end
   end

   assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_fadd_share_arb.sv
// Directed bench for fadd_share_arb: hand-computed sums, grant order, stall, reset, wrap.
module tb_fadd_share_arb;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [3:0]   req_valid;
   logic [3:0]   req_ready;
   logic [127:0] req_a;
   logic [127:0] req_b;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [31:0]  rsp_sum;
   logic [1:0]   rsp_id;
`ifdef FADD_ARB_STATS_EN
   logic [3:0]   op_count;
`endif

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] t2_a   [4] = '{32'h3F800000, 32'h40000000, 32'h40800000, 32'h41200000};
   logic [31:0] t2_b   [4] = '{32'h3F800000, 32'h40400000, 32'hBFC00000, 32'h41200000};
   logic [31:0] t2_sum [4] = '{32'h40000000, 32'h40A00000, 32'h40200000, 32'h41A00000};

   always #5 clk = ~clk;

   fadd_share_arb #(
      .N_REQ (4),
      .ID_W  (2)
`ifdef FADD_ARB_STATS_EN
      ,
      .CNT_W (4)
`endif
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_sum   (rsp_sum),
      .rsp_id    (rsp_id)
`ifdef FADD_ARB_STATS_EN
      ,
      .op_count  (op_count)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
      req_a[32*i +: 32] = a;
      req_b[32*i +: 32] = b;
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = 4'h0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b0;
      #12;
      chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_sum", rsp_sum, 32'd0);
      chk("rst_id", {30'd0, rsp_id}, 32'd0);
      chk("rst_ready", {28'd0, req_ready}, 32'd0);
      step();
      rst_n = 1'b1;
      step();

      // 1: single op 1.0 + 2.0
      set_req(0, 32'h3F800000, 32'h40000000);
      req_valid = 4'h1;
      rsp_ready = 1'b1;
      #1;
      chk("t1_grant", {28'd0, req_ready}, 32'h1);
      step();
      req_valid = 4'h0;
      #1;
      chk("t1_calc_valid", {31'd0, rsp_valid}, 32'd0);
      chk("t1_calc_ready", {28'd0, req_ready}, 32'd0);
      step();
      chk("t1_valid", {31'd0, rsp_valid}, 32'd1);
      chk("t1_sum", rsp_sum, 32'h40400000);
      chk("t1_id", {30'd0, rsp_id}, 32'd0);
      step();
      chk("t1_idle_valid", {31'd0, rsp_valid}, 32'd0);

      // 5: reset during CALC drops the work
      for (int i = 0; i < 4; i++) set_req(i, t2_a[i], t2_b[i]);
      req_valid = 4'h4;
      #1;
      chk("t5_grant", {28'd0, req_ready}, 32'h4);
      step();
      req_valid = 4'h0;
      #1;
      chk("t5_calc_valid", {31'd0, rsp_valid}, 32'd0);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_valid", {31'd0, rsp_valid}, 32'd0);
      chk("t5_rst_sum", rsp_sum, 32'd0);
      #1;
      rst_n = 1'b1;
      step();
      chk("t5_dropped", {31'd0, rsp_valid}, 32'd0);

      // 2: all requesters valid, order 0,1,2,3,0
      req_valid = 4'hF;
      #1;
      chk("t2_first_grant", {28'd0, req_ready}, 32'h1);
      for (int k = 0; k < 5; k++) begin
         step();
         chk("t2_calc_valid", {31'd0, rsp_valid}, 32'd0);
         chk("t2_calc_ready", {28'd0, req_ready}, 32'd0);
         step();
         chk("t2_valid", {31'd0, rsp_valid}, 32'd1);
         chk("t2_sum", rsp_sum, t2_sum[k % 4]);
         chk("t2_id", {30'd0, rsp_id}, 32'(k % 4));
         if (k < 4) chk("t2_next_grant", {28'd0, req_ready}, 32'(1 << ((k + 1) % 4)));
      end

      // 3: sink stalls in HOLD
      rsp_ready = 1'b0;
      #1;
      chk("t3_no_grant", {28'd0, req_ready}, 32'd0);
      for (int k = 0; k < 5; k++) begin
         step();
         chk("t3_valid", {31'd0, rsp_valid}, 32'd1);
         chk("t3_sum", rsp_sum, 32'h40000000);
         chk("t3_id", {30'd0, rsp_id}, 32'd0);
         chk("t3_ready", {28'd0, req_ready}, 32'd0);
      end

      // 4: back-to-back grant to req2 from HOLD
      req_valid = 4'h4;
      rsp_ready = 1'b1;
      #1;
      chk("t4_grant", {28'd0, req_ready}, 32'h4);
      step();
      req_valid = 4'h0;
      #1;
      chk("t4_calc_valid", {31'd0, rsp_valid}, 32'd0);
      step();
      chk("t4_valid", {31'd0, rsp_valid}, 32'd1);
      chk("t4_sum", rsp_sum, 32'h40200000);
      chk("t4_id", {30'd0, rsp_id}, 32'd2);
      step();
      chk("t4_idle_valid", {31'd0, rsp_valid}, 32'd0);

      // Single requester every opportunity; rounding tie and exact zero
      set_req(3, 32'h3F800000, 32'h33800000);
      req_valid = 4'h8;
      #1;
      chk("rr_wrap_grant", {28'd0, req_ready}, 32'h8);
      step();
      set_req(3, 32'h3F800000, 32'hBF800000);
      step();
      chk("tie_sum", rsp_sum, 32'h3F800000);
      chk("tie_id", {30'd0, rsp_id}, 32'd3);
      chk("single_regrant", {28'd0, req_ready}, 32'h8);
      step();
      step();
      chk("zero_sum", rsp_sum, 32'h00000000);
      chk("zero_id", {30'd0, rsp_id}, 32'd3);
      req_valid = 4'h0;
      step();
      chk("end_idle_valid", {31'd0, rsp_valid}, 32'd0);

`ifdef FADD_ARB_STATS_EN
      // 6: saturating response counter
      chk("stat_count8", {28'd0, op_count}, 32'd8);
      set_req(0, 32'h3F800000, 32'h3F800000);
      req_valid = 4'h1;
      for (int k = 0; k < 30; k++) step();
      req_valid = 4'h0;
      for (int k = 0; k < 3; k++) step();
      chk("stat_saturate", {28'd0, op_count}, 32'hF);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
